// File: rtl/icache_pkg.sv
// Shared types and address-field helpers for the direct-mapped instruction cache.
package icache_pkg;

  localparam int unsigned ADDRW = 32;
  localparam int unsigned DATAW = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    REFILL = 2'd2
  } icache_state_e;

  // Field widths of the word address: [byte | word offset | index | tag]
  function automatic int unsigned off_w(input int unsigned line_words);
    return $clog2(line_words);
  endfunction

  function automatic int unsigned idx_w(input int unsigned num_lines);
    return $clog2(num_lines);
  endfunction

  function automatic int unsigned tag_w(input int unsigned num_lines, input int unsigned line_words);
    return ADDRW - 2 - off_w(line_words) - idx_w(num_lines);
  endfunction

endpackage

// File: rtl/icache_array.sv
// Valid/tag/data storage for the instruction cache: combinational read by index,
// synchronous word and tag writes, valid bits cleared by reset or flush.
module icache_array
  import icache_pkg::*;
#(
  parameter int unsigned NUM_LINES  = 16,
  parameter int unsigned LINE_WORDS = 4,
  localparam int unsigned OFFW = off_w(LINE_WORDS),
  localparam int unsigned IDXW = idx_w(NUM_LINES),
  localparam int unsigned TAGW = tag_w(NUM_LINES, LINE_WORDS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic [IDXW-1:0]   idx,
  input  logic [OFFW-1:0]   rd_word,
  output logic              rd_valid,
  output logic [TAGW-1:0]   rd_tag,
  output logic [DATAW-1:0]  rd_data,
  input  logic              word_we,
  input  logic [OFFW-1:0]   wr_word,
  input  logic [DATAW-1:0]  wr_data,
  input  logic              tag_we,
  input  logic [TAGW-1:0]   wr_tag,
  input  logic              set_valid
);

  logic [NUM_LINES-1:0] valid;
  logic [TAGW-1:0]      tags [NUM_LINES];
  logic [DATAW-1:0]     data [NUM_LINES][LINE_WORDS];

  assign rd_valid = valid[idx];
  assign rd_tag   = tags[idx];
  assign rd_data  = data[idx][rd_word];

  // Flush wins over a same-cycle tag write so a line filled under flush stays invalid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
    end else if (flush) begin
      valid <= '0;
    end else if (tag_we) begin
      valid[idx] <= set_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (word_we) begin
      data[idx][wr_word] <= wr_data;
    end
    if (tag_we) begin
      tags[idx] <= wr_tag;
    end
  end

endmodule

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache: 1-cycle hits, word-by-word line refill
// from a req/ack backing memory port on a miss.
module icache
  import icache_pkg::*;
#(
  parameter int unsigned NUM_LINES  = 16,
  parameter int unsigned LINE_WORDS = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [ADDRW-1:0]  imem_addr_i,
  input  logic              imem_valid_i,
  output logic [DATAW-1:0]  imem_rdata_o,
  output logic              imem_resp_o,
  input  logic              flush_i,
  output logic [ADDRW-1:0]  mem_addr_o,
  output logic              mem_req_o,
  input  logic [DATAW-1:0]  mem_rdata_i,
  input  logic              mem_ack_i
);

  localparam int unsigned OFFW     = off_w(LINE_WORDS);
  localparam int unsigned IDXW     = idx_w(NUM_LINES);
  localparam int unsigned TAGW     = tag_w(NUM_LINES, LINE_WORDS);
  localparam int unsigned LINE_LSB = 2 + OFFW;

  icache_state_e    state_q, state_d;
  logic [ADDRW-1:0] req_q, req_d;
  logic [OFFW-1:0]  beat_q, beat_d;
  logic             flush_pend_q, flush_pend_d;

  logic [IDXW-1:0]  idx;
  logic [OFFW-1:0]  word;
  logic [TAGW-1:0]  tag;
  logic             rd_valid;
  logic [TAGW-1:0]  rd_tag;
  logic [DATAW-1:0] rd_data;
  logic             hit;
  logic             last_beat;
  logic             resp;
  logic             mem_req;
  logic             word_we;
  logic             tag_we;
  logic             set_valid;
  logic             unused_byte_bits;

  assign idx              = req_q[LINE_LSB +: IDXW];
  assign word             = req_q[2 +: OFFW];
  assign tag              = req_q[ADDRW-1 -: TAGW];
  assign unused_byte_bits = ^{imem_addr_i[1:0], req_q[1:0]};
  assign hit              = rd_valid && (rd_tag == tag);
  assign last_beat        = (beat_q == OFFW'(LINE_WORDS - 1));

  icache_array #(
    .NUM_LINES  (NUM_LINES),
    .LINE_WORDS (LINE_WORDS)
  ) u_array (
    .clk       (clk_i),
    .rst_n     (rst_ni),
    .flush     (flush_i),
    .idx       (idx),
    .rd_word   (word),
    .rd_valid  (rd_valid),
    .rd_tag    (rd_tag),
    .rd_data   (rd_data),
    .word_we   (word_we),
    .wr_word   (beat_q),
    .wr_data   (mem_rdata_i),
    .tag_we    (tag_we),
    .wr_tag    (tag),
    .set_valid (set_valid)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      req_q        <= '0;
      beat_q       <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      beat_q       <= beat_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  // Next state and array control; a flush seen during refill keeps the new line invalid
  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    beat_d       = beat_q;
    flush_pend_d = flush_pend_q;
    resp         = 1'b0;
    mem_req      = 1'b0;
    word_we      = 1'b0;
    tag_we       = 1'b0;
    set_valid    = 1'b0;
    case (state_q)
      IDLE: begin
        if (imem_valid_i) begin
          req_d   = imem_addr_i;
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        if (flush_i) begin
          state_d = IDLE;
        end else if (hit) begin
          resp = 1'b1;
          if (imem_valid_i) begin
            req_d = imem_addr_i;
          end else begin
            state_d = IDLE;
          end
        end else begin
          beat_d  = '0;
          state_d = REFILL;
        end
      end
      REFILL: begin
        mem_req = 1'b1;
        if (flush_i) begin
          flush_pend_d = 1'b1;
        end
        if (mem_ack_i) begin
          word_we = 1'b1;
          beat_d  = beat_q + OFFW'(1);
          if (last_beat) begin
            tag_we       = 1'b1;
            set_valid    = !(flush_pend_q || flush_i);
            flush_pend_d = 1'b0;
            state_d      = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign imem_resp_o  = resp;
  assign imem_rdata_o = resp ? rd_data : '0;
  assign mem_req_o    = mem_req;
  assign mem_addr_o   = mem_req ? {req_q[ADDRW-1:LINE_LSB], beat_q, 2'b00} : '0;

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: directed scenarios plus randomized fetches
// against a line-level cache model and a reactive backing memory.
module tb_icache;

  localparam int unsigned NUM_LINES  = 16;
  localparam int unsigned LINE_WORDS = 4;
  localparam int unsigned OFFW       = $clog2(LINE_WORDS);
  localparam int unsigned IDXW       = $clog2(NUM_LINES);

  logic        clk = 1'b0;
  logic        rst_ni;
  logic [31:0] imem_addr_i;
  logic        imem_valid_i;
  logic [31:0] imem_rdata_o;
  logic        imem_resp_o;
  logic        flush_i;
  logic [31:0] mem_addr_o;
  logic        mem_req_o;
  logic [31:0] mem_rdata_i;
  logic        mem_ack_i;

  int          total = 0;
  int          bad = 0;
  int          ack_delay = 1;
  int          wait_cnt = 0;
  bit          mem_model_en = 1'b1;
  logic [31:0] ack_log [$];

  bit          m_valid [NUM_LINES];
  logic [31:0] m_tag [NUM_LINES];

  icache #(
    .NUM_LINES  (NUM_LINES),
    .LINE_WORDS (LINE_WORDS)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .imem_addr_i  (imem_addr_i),
    .imem_valid_i (imem_valid_i),
    .imem_rdata_o (imem_rdata_o),
    .imem_resp_o  (imem_resp_o),
    .flush_i      (flush_i),
    .mem_addr_o   (mem_addr_o),
    .mem_req_o    (mem_req_o),
    .mem_rdata_i  (mem_rdata_i),
    .mem_ack_i    (mem_ack_i)
  );

  always #5 clk = ~clk;

  // Backing memory: acks in the ack_delay-th cycle of each request, data = 0x13 + addr
  always @(negedge clk) begin
    if (mem_model_en) begin
      if (mem_req_o) begin
        if (wait_cnt + 1 >= ack_delay) begin
          mem_ack_i   = 1'b1;
          mem_rdata_i = mem_addr_o + 32'h13;
          ack_log.push_back(mem_addr_o);
          wait_cnt    = 0;
        end else begin
          mem_ack_i = 1'b0;
          wait_cnt  = wait_cnt + 1;
        end
      end else begin
        mem_ack_i = 1'b0;
        wait_cnt  = 0;
      end
    end
  end

  // Reference model: which memory line each cache slot holds
  function automatic int m_idx(input logic [31:0] a);
    return int'((a >> (2 + OFFW)) % NUM_LINES);
  endfunction

  function automatic bit m_hit(input logic [31:0] a);
    return m_valid[m_idx(a)] && (m_tag[m_idx(a)] == (a >> (2 + OFFW + IDXW)));
  endfunction

  function automatic logic [31:0] exp_data(input logic [31:0] a);
    return (a & ~32'h3) + 32'h13;
  endfunction

  function automatic int exp_edges(input bit h, input int d);
    return h ? 1 : 3 + LINE_WORDS * d;
  endfunction

  task automatic m_fill(input logic [31:0] a);
    m_valid[m_idx(a)] = 1'b1;
    m_tag[m_idx(a)]   = a >> (2 + OFFW + IDXW);
  endtask

  task automatic m_clear();
    for (int i = 0; i < NUM_LINES; i++) m_valid[i] = 1'b0;
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Present an address until the cache responds; returns data and edge count
  task automatic fetch(input logic [31:0] a, output logic [31:0] d, output int edges, output bit ok);
    ok = 1'b0; edges = 0; d = '0;
    imem_addr_i = a; imem_valid_i = 1'b1;
    for (int i = 0; i < 300; i++) begin
      tick();
      edges++;
      if (imem_resp_o) begin
        d = imem_rdata_o; ok = 1'b1;
        break;
      end
    end
    imem_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    total++; if (imem_resp_o !== 1'b0) begin bad++; $display("FAIL rst_resp got=%b exp=0", imem_resp_o); end
    total++; if (imem_rdata_o !== 32'h0) begin bad++; $display("FAIL rst_rdata got=%h exp=0", imem_rdata_o); end
    total++; if (mem_req_o !== 1'b0) begin bad++; $display("FAIL rst_req got=%b exp=0", mem_req_o); end
    total++; if (mem_addr_o !== 32'h0) begin bad++; $display("FAIL rst_maddr got=%h exp=0", mem_addr_o); end
    tick(); tick();
    rst_ni = 1'b1;
    tick();
    total++; if (mem_req_o !== 1'b0 || imem_resp_o !== 1'b0) begin bad++; $display("FAIL idle_after_rst req=%b resp=%b exp=0/0", mem_req_o, imem_resp_o); end
  endtask

  task automatic test_cold_miss_seq();
    logic [31:0] addrs [4];
    logic [31:0] rdat [4];
    int          redge [4];
    int          k, edges;
    for (int j = 0; j < 4; j++) addrs[j] = 32'h8000_0000 + 32'(4 * j);
    ack_delay = 1; ack_log.delete(); k = 0; edges = 0;
    imem_addr_i = addrs[0]; imem_valid_i = 1'b1;
    for (int i = 0; i < 50 && k < 4; i++) begin
      tick();
      edges++;
      if (imem_resp_o) begin
        redge[k] = edges; rdat[k] = imem_rdata_o; k++;
        if (k < 4) imem_addr_i = addrs[k];
      end
    end
    imem_valid_i = 1'b0;
    total++; if (k !== 4) begin bad++; $display("FAIL cold_resp_count got=%0d exp=4", k); end
    for (int j = 0; j < k; j++) begin
      total++; if (rdat[j] !== exp_data(addrs[j])) begin bad++; $display("FAIL cold_data[%0d] got=%h exp=%h", j, rdat[j], exp_data(addrs[j])); end
      total++; if (redge[j] !== 7 + j) begin bad++; $display("FAIL cold_edge[%0d] got=%0d exp=%0d", j, redge[j], 7 + j); end
    end
    total++; if (ack_log.size() !== 4) begin bad++; $display("FAIL cold_beats got=%0d exp=4", ack_log.size()); end
    for (int j = 0; j < ack_log.size() && j < 4; j++) begin
      total++; if (ack_log[j] !== addrs[j]) begin bad++; $display("FAIL cold_maddr[%0d] got=%h exp=%h", j, ack_log[j], addrs[j]); end
    end
    m_fill(addrs[0]);
  endtask

  task automatic test_redirect();
    logic [31:0] d;
    int          edges;
    bit          ok, redirected, h;
    ack_delay = 1; ack_log.delete(); redirected = 1'b0; ok = 1'b0; edges = 0; d = '0;
    imem_addr_i = 32'h8000_0010; imem_valid_i = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      edges++;
      if (!redirected && mem_req_o && ack_log.size() == 2) begin
        imem_addr_i = 32'h8000_0100; redirected = 1'b1;
      end
      if (imem_resp_o) begin d = imem_rdata_o; ok = 1'b1; break; end
    end
    imem_valid_i = 1'b0;
    total++; if (!ok || d !== 32'h8000_0113) begin bad++; $display("FAIL redir_data ok=%b got=%h exp=80000113", ok, d); end
    total++; if (edges !== 13) begin bad++; $display("FAIL redir_edges got=%0d exp=13", edges); end
    total++; if (ack_log.size() !== 8) begin bad++; $display("FAIL redir_beats got=%0d exp=8", ack_log.size()); end
    for (int j = 0; j < ack_log.size() && j < 8; j++) begin
      logic [31:0] ea;
      ea = (j < 4) ? 32'h8000_0010 + 32'(4 * j) : 32'h8000_0100 + 32'(4 * (j - 4));
      total++; if (ack_log[j] !== ea) begin bad++; $display("FAIL redir_maddr[%0d] got=%h exp=%h", j, ack_log[j], ea); end
    end
    m_fill(32'h8000_0010); m_fill(32'h8000_0100);
    h = m_hit(32'h8000_0014);
    fetch(32'h8000_0014, d, edges, ok);
    total++; if (!ok || d !== exp_data(32'h8000_0014)) begin bad++; $display("FAIL redir_line_data got=%h exp=%h", d, exp_data(32'h8000_0014)); end
    total++; if (edges !== exp_edges(h, ack_delay)) begin bad++; $display("FAIL redir_line_edges got=%0d exp=%0d", edges, exp_edges(h, ack_delay)); end
  endtask

  task automatic test_conflict();
    logic [31:0] addrs [3];
    logic [31:0] d;
    int          edges;
    bit          ok, h;
    addrs[0] = 32'h8000_0000; addrs[1] = 32'h8000_0100; addrs[2] = 32'h8000_0000;
    ack_delay = 1;
    for (int j = 0; j < 3; j++) begin
      h = m_hit(addrs[j]);
      ack_log.delete();
      fetch(addrs[j], d, edges, ok);
      total++; if (!ok || d !== exp_data(addrs[j])) begin bad++; $display("FAIL conflict_data[%0d] got=%h exp=%h", j, d, exp_data(addrs[j])); end
      total++; if (edges !== exp_edges(h, ack_delay)) begin bad++; $display("FAIL conflict_edges[%0d] got=%0d exp=%0d", j, edges, exp_edges(h, ack_delay)); end
      total++; if (ack_log.size() !== (h ? 0 : LINE_WORDS)) begin bad++; $display("FAIL conflict_beats[%0d] got=%0d exp=%0d", j, ack_log.size(), h ? 0 : LINE_WORDS); end
      if (!h) m_fill(addrs[j]);
    end
  endtask

  task automatic test_flush();
    logic [31:0] d;
    int          edges;
    bit          ok, h;
    imem_addr_i = 32'h8000_0000; imem_valid_i = 1'b1;
    tick();
    total++; if (imem_resp_o !== 1'b1) begin bad++; $display("FAIL flush_prehit got=%b exp=1", imem_resp_o); end
    flush_i = 1'b1; imem_valid_i = 1'b0;
    #1;
    total++; if (imem_resp_o !== 1'b0 || imem_rdata_o !== 32'h0) begin bad++; $display("FAIL flush_resp got=%b/%h exp=0/0", imem_resp_o, imem_rdata_o); end
    tick();
    flush_i = 1'b0;
    m_clear();
    h = m_hit(32'h8000_0000);
    fetch(32'h8000_0000, d, edges, ok);
    total++; if (!ok || d !== exp_data(32'h8000_0000)) begin bad++; $display("FAIL flush_refetch_data got=%h exp=%h", d, exp_data(32'h8000_0000)); end
    total++; if (edges !== exp_edges(h, ack_delay)) begin bad++; $display("FAIL flush_refetch_edges got=%0d exp=%0d", edges, exp_edges(h, ack_delay)); end
    m_fill(32'h8000_0000);
  endtask

  task automatic test_flush_refill();
    logic [31:0] d, prev_addr;
    int          edges, stable_bad;
    bit          ok, flushed, prev_req, prev_ack;
    ack_delay = 3; ack_log.delete(); flushed = 1'b0; prev_req = 1'b0; prev_ack = 1'b0;
    prev_addr = '0; edges = 0; ok = 1'b0; d = '0; stable_bad = 0;
    imem_addr_i = 32'h8000_0040; imem_valid_i = 1'b1;
    for (int i = 0; i < 200; i++) begin
      tick();
      edges++;
      if (prev_req && !prev_ack) begin
        total++;
        if (mem_req_o !== 1'b1 || mem_addr_o !== prev_addr) begin
          bad++; stable_bad++;
          if (stable_bad < 4) $display("FAIL bp_stable req=%b addr=%h exp=1/%h", mem_req_o, mem_addr_o, prev_addr);
        end
      end
      flush_i = 1'b0;
      if (!flushed && mem_req_o && mem_addr_o[3:2] == 2'd2) begin
        flush_i = 1'b1; flushed = 1'b1;
      end
      prev_req = mem_req_o; prev_ack = mem_ack_i; prev_addr = mem_addr_o;
      if (imem_resp_o) begin d = imem_rdata_o; ok = 1'b1; break; end
    end
    flush_i = 1'b0; imem_valid_i = 1'b0;
    total++; if (!ok || d !== exp_data(32'h8000_0040)) begin bad++; $display("FAIL bp_data ok=%b got=%h exp=%h", ok, d, exp_data(32'h8000_0040)); end
    total++; if (edges !== 2 * (exp_edges(1'b0, 3) - 1) + 1) begin bad++; $display("FAIL bp_edges got=%0d exp=%0d", edges, 2 * (exp_edges(1'b0, 3) - 1) + 1); end
    total++; if (ack_log.size() !== 2 * LINE_WORDS) begin bad++; $display("FAIL bp_beats got=%0d exp=%0d", ack_log.size(), 2 * LINE_WORDS); end
    total++; if (!flushed) begin bad++; $display("FAIL bp_flush_issued got=0 exp=1"); end
    m_clear();
    m_fill(32'h8000_0040);
    ack_delay = 1;
  endtask

  task automatic test_reset_mid_refill();
    logic [31:0] d;
    int          edges;
    bit          ok, found, h;
    ack_delay = 1; found = 1'b0;
    imem_addr_i = 32'h8000_0080; imem_valid_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (mem_req_o && mem_addr_o == 32'h8000_0084) begin found = 1'b1; break; end
    end
    total++; if (!found) begin bad++; $display("FAIL rmid_beat1_seen got=0 exp=1"); end
    #2 rst_ni = 1'b0;
    imem_valid_i = 1'b0;
    #1;
    total++; if (mem_req_o !== 1'b0 || mem_addr_o !== 32'h0) begin bad++; $display("FAIL rmid_req got=%b/%h exp=0/0", mem_req_o, mem_addr_o); end
    total++; if (imem_resp_o !== 1'b0 || imem_rdata_o !== 32'h0) begin bad++; $display("FAIL rmid_resp got=%b/%h exp=0/0", imem_resp_o, imem_rdata_o); end
    tick(); tick();
    rst_ni = 1'b1;
    mem_model_en = 1'b0; mem_ack_i = 1'b1; mem_rdata_i = 32'hDEAD_BEEF;
    tick();
    total++; if (mem_req_o !== 1'b0 || imem_resp_o !== 1'b0) begin bad++; $display("FAIL rmid_stray req=%b resp=%b exp=0/0", mem_req_o, imem_resp_o); end
    mem_ack_i = 1'b0; mem_model_en = 1'b1;
    m_clear();
    h = m_hit(32'h8000_0080);
    fetch(32'h8000_0080, d, edges, ok);
    total++; if (!ok || d !== exp_data(32'h8000_0080)) begin bad++; $display("FAIL rmid_refetch_data got=%h exp=%h", d, exp_data(32'h8000_0080)); end
    total++; if (edges !== exp_edges(h, ack_delay)) begin bad++; $display("FAIL rmid_refetch_edges got=%0d exp=%0d", edges, exp_edges(h, ack_delay)); end
    m_fill(32'h8000_0080);
  endtask

  task automatic test_random();
    logic [31:0] bases [3];
    logic [31:0] a, d;
    int          edges;
    bit          ok, h;
    bases[0] = 32'h8000_0000; bases[1] = 32'h8000_0100; bases[2] = 32'h9000_0000;
    for (int n = 0; n < 60; n++) begin
      ack_delay = int'($urandom_range(1, 3));
      if ($urandom_range(0, 7) == 0) begin
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        m_clear();
      end
      a = bases[$urandom_range(0, 2)] + 32'($urandom_range(0, 63));
      h = m_hit(a);
      fetch(a, d, edges, ok);
      total++; if (!ok || d !== exp_data(a)) begin bad++; $display("FAIL rand_data[%0d] addr=%h got=%h exp=%h", n, a, d, exp_data(a)); end
      total++; if (edges !== exp_edges(h, ack_delay)) begin bad++; $display("FAIL rand_edges[%0d] addr=%h got=%0d exp=%0d", n, a, edges, exp_edges(h, ack_delay)); end
      if (!h) m_fill(a);
    end
  endtask

  initial begin
    rst_ni = 1'b0; imem_addr_i = '0; imem_valid_i = 1'b0; flush_i = 1'b0;
    mem_rdata_i = '0; mem_ack_i = 1'b0;
    m_clear();
    test_reset();
    test_cold_miss_seq();
    test_redirect();
    test_conflict();
    test_flush();
    test_flush_refill();
    test_reset_mid_refill();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
